hazard_bypass_unit: RTL and testbench
=====================================

Name: hazard_bypass_unit

Overview:
- Next-generation hazard/forwarding block for the 5-stage MIPS pipeline, parametrised in data and register-address width.
- Merges EX-stage operand bypassing (EX/MEM > MEM/WB > regfile) with ID-stage hazard detection:
  - load-use stall;
  - scoreboard FSM for one non-pipelined multi-cycle mul/div unit.
- Drives PC/IF-ID hold, the ID/EX bubble, and the ALU operand muxes.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register specifier width
MULDIV_LAT, 4, mul/div latency in cycles, from accept to result write (legal >= 2)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
if_id_rs  in  REG_ADDR_W  ID-stage source A specifier
if_id_rt  in  REG_ADDR_W  ID-stage source B specifier
if_id_uses_rs  in  1  ID instruction reads rs
if_id_uses_rt  in  1  ID instruction reads rt
if_id_is_muldiv  in  1  ID instruction is a mul/div
if_id_muldiv_rd  in  REG_ADDR_W  mul/div destination
id_ex_rs  in  REG_ADDR_W  EX-stage source A
id_ex_rt  in  REG_ADDR_W  EX-stage source B
id_ex_rd  in  REG_ADDR_W  EX-stage destination
id_ex_mem_read  in  1  EX instruction is a load
ex_mem_rd  in  REG_ADDR_W  MEM-stage destination
ex_mem_reg_write  in  1  MEM-stage writes regfile
ex_mem_alu_result  in  DATA_W  MEM-stage ALU result
mem_wb_rd  in  REG_ADDR_W  WB-stage destination
mem_wb_reg_write  in  1  WB-stage writes regfile
mem_wb_data  in  DATA_W  WB write data
reg_a_data  in  DATA_W  regfile read A (EX)
reg_b_data  in  DATA_W  regfile read B (EX)
alu_src_a  out  DATA_W  bypassed operand A
alu_src_b_reg  out  DATA_W  bypassed operand B (before immediate mux)
forward_a  out  2  A select: 00 reg, 01 MEM/WB, 10 EX/MEM
forward_b  out  2  B select, same encoding
stall  out  1  hold PC and IF/ID
id_ex_flush  out  1  insert bubble into ID/EX
muldiv_busy  out  1  scoreboard FSM in BUSY
muldiv_done  out  1  final mul/div cycle

Behaviour:
- Forwarding (combinational, zero latency):
  - Per operand, EX/MEM hit = (src == ex_mem_rd) and src != 0 and ex_mem_reg_write.
  - MEM/WB hit = same test against mem_wb_rd / mem_wb_reg_write.
  - Priority: EX/MEM hit (10) > MEM/WB hit (01) > none (00).
  - Specifier 0 is never forwarded; select 11 never produced.
- Load-use:
  - load_use = id_ex_mem_read and id_ex_rd != 0 and ((if_id_uses_rs and if_id_rs == id_ex_rd) or (if_id_uses_rt and if_id_rt == id_ex_rd)).
  - Exactly one stall cycle per occurrence.
- Scoreboard FSM, states IDLE and BUSY; registers cnt (width clog2(MULDIV_LAT+1)) and pending_rd.
  - IDLE: if_id_is_muldiv and no stall → at clock edge load cnt = MULDIV_LAT, pending_rd = if_id_muldiv_rd, go BUSY.
  - BUSY: cnt decrements each cycle.
  - muldiv_done = BUSY and cnt == 1; next state IDLE.
  - Result writes regfile at the edge ending the done cycle.
- sb_hit = BUSY and pending_rd != 0 and (if_id_uses_rs and rs == pending_rd, or if_id_uses_rt and rt == pending_rd).
- sb_struct = BUSY and if_id_is_muldiv.
- stall = load_use or sb_hit or sb_struct; id_ex_flush = stall.
- A dependent reader is still stalled in the done cycle and released the following cycle.
- A new mul/div is stalled in the done cycle and accepted on the next cycle from IDLE; no back-to-back accept.
- muldiv_busy = (state == BUSY).
- pending_rd == 0: the op still occupies the unit (structural stall applies) but causes no data stall.
- Reset: state IDLE, cnt 0, pending_rd 0.
  - stall, id_ex_flush, muldiv_busy, muldiv_done = 0.
  - Forwarding outputs follow their combinational inputs.
  - rst_n asserted mid-BUSY aborts the op immediately; nothing is retained.

Optional Feature:
HAZ_STALL_CNT_EN:
- Defined: adds output stall_cycles [31:0].
  - Counts clock cycles with stall = 1.
  - Saturates at 32'hFFFF_FFFF; reset to 0 by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- EX/MEM forward: id_ex_rs=3, ex_mem_rd=3, ex_mem_reg_write=1, ex_mem_alu_result=32'h1234 → forward_a=10, alu_src_a=32'h1234.
- EX/MEM priority and r0 block:
  - Same rd=3 also in MEM/WB with data 32'hBEEF → EX/MEM value wins.
  - id_ex_rs=0 with rd=0 writes → forward_a=00.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rt=5, uses_rt=1 → stall=id_ex_flush=1 for exactly 1 cycle; forward_b=01 after bubble.
- Mul/div dependency, MULDIV_LAT=4:
  - Accept with rd=7, then reader of r7 → stall for 4 cycles.
  - muldiv_done high in cycle 4; stall drops in cycle 5.
- Structural: second mul/div issued one cycle after the first → stalled until the cycle after done, then muldiv_busy reasserts.
- Async reset mid-BUSY (cnt=2) → muldiv_busy and stall drop immediately without a clock; with HAZ_STALL_CNT_EN, stall_cycles reads 0.

Source files
------------

// File: rtl/hazard_bypass_unit_if.sv
// Pipeline-side bundle for hazard_bypass_unit: ID/EX/MEM/WB fields in, operand muxes and hazard controls out.
// Latency: none (wires only); the unit's forwarding and stall decode are combinational from these fields.
// Backpressure: stall/id_ex_flush returned here hold the front end; stall_cycles exists only with HAZ_STALL_CNT_EN.
interface hazard_bypass_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    // ID stage
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic                  if_id_uses_rs;
    logic                  if_id_uses_rt;
    logic                  if_id_is_muldiv;
    logic [REG_ADDR_W-1:0] if_id_muldiv_rd;
    // EX stage
    logic [REG_ADDR_W-1:0] id_ex_rs;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic                  id_ex_mem_read;
    // MEM stage
    logic [REG_ADDR_W-1:0] ex_mem_rd;
    logic                  ex_mem_reg_write;
    logic [DATA_W-1:0]     ex_mem_alu_result;
    // WB stage
    logic [REG_ADDR_W-1:0] mem_wb_rd;
    logic                  mem_wb_reg_write;
    logic [DATA_W-1:0]     mem_wb_data;
    // Regfile reads feeding EX
    logic [DATA_W-1:0]     reg_a_data;
    logic [DATA_W-1:0]     reg_b_data;
    // Results
    logic [DATA_W-1:0]     alu_src_a;
    logic [DATA_W-1:0]     alu_src_b_reg;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall;
    logic                  id_ex_flush;
    logic                  muldiv_busy;
    logic                  muldiv_done;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0]           stall_cycles;
`endif

    // Pipeline side: drives stage fields, consumes hazard controls.
    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, if_id_is_muldiv, if_id_muldiv_rd,
        output id_ex_rs, id_ex_rt, id_ex_rd, id_ex_mem_read,
        output ex_mem_rd, ex_mem_reg_write, ex_mem_alu_result,
        output mem_wb_rd, mem_wb_reg_write, mem_wb_data,
        output reg_a_data, reg_b_data,
        input  alu_src_a, alu_src_b_reg, forward_a, forward_b,
        input  stall, id_ex_flush, muldiv_busy, muldiv_done
`ifdef HAZ_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    // Hazard unit side.
    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, if_id_is_muldiv, if_id_muldiv_rd,
        input  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_mem_read,
        input  ex_mem_rd, ex_mem_reg_write, ex_mem_alu_result,
        input  mem_wb_rd, mem_wb_reg_write, mem_wb_data,
        input  reg_a_data, reg_b_data,
        output alu_src_a, alu_src_b_reg, forward_a, forward_b,
        output stall, id_ex_flush, muldiv_busy, muldiv_done
`ifdef HAZ_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_bypass_unit.sv
// Hazard/forwarding unit for the 5-stage MIPS pipe: EX operand bypass, load-use stall, mul/div scoreboard.
// Latency: forwarding and stall are combinational; the scoreboard holds a mul/div for MULDIV_LAT cycles.
// Backpressure: stall holds PC/IF-ID and id_ex_flush bubbles ID/EX; optional HAZ_STALL_CNT_EN adds stall_cycles.
module hazard_bypass_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4
) (
    input logic                clk,
    input logic                rst_n,
    hazard_bypass_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_t;

    sb_state_t             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REG_ADDR_W-1:0] pending_rd_q;
    logic                  done_q;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [DATA_W-1:0]     src_a;
    logic [DATA_W-1:0]     src_b;
    logic                  load_use;
    logic                  sb_hit;
    logic                  sb_struct;
    logic                  stall;

    // Operand bypass select: youngest producer (EX/MEM) wins over MEM/WB; r0 is never bypassed.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (bus.ex_mem_reg_write && bus.ex_mem_rd != '0 && bus.id_ex_rs == bus.ex_mem_rd)
            fwd_a = 2'b10;
        else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.id_ex_rs == bus.mem_wb_rd)
            fwd_a = 2'b01;
        if (bus.ex_mem_reg_write && bus.ex_mem_rd != '0 && bus.id_ex_rt == bus.ex_mem_rd)
            fwd_b = 2'b10;
        else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.id_ex_rt == bus.mem_wb_rd)
            fwd_b = 2'b01;
    end

    // Operand muxes driven by the selects above.
    always_comb begin
        src_a = bus.reg_a_data;
        src_b = bus.reg_b_data;
        case (fwd_a)
            2'b10:   src_a = bus.ex_mem_alu_result;
            2'b01:   src_a = bus.mem_wb_data;
            default: src_a = bus.reg_a_data;
        endcase
        case (fwd_b)
            2'b10:   src_b = bus.ex_mem_alu_result;
            2'b01:   src_b = bus.mem_wb_data;
            default: src_b = bus.reg_b_data;
        endcase
    end

    // ID-stage hazard decode. Reset gates stall so controls read 0 while rst_n is low,
    // even if the pipeline registers upstream still hold a load-use pattern.
    always_comb begin
        load_use  = bus.id_ex_mem_read && bus.id_ex_rd != '0 &&
                    ((bus.if_id_uses_rs && bus.if_id_rs == bus.id_ex_rd) ||
                     (bus.if_id_uses_rt && bus.if_id_rt == bus.id_ex_rd));
        sb_hit    = state_q == SB_BUSY && pending_rd_q != '0 &&
                    ((bus.if_id_uses_rs && bus.if_id_rs == pending_rd_q) ||
                     (bus.if_id_uses_rt && bus.if_id_rt == pending_rd_q));
        sb_struct = state_q == SB_BUSY && bus.if_id_is_muldiv;
        stall     = rst_n && (load_use || sb_hit || sb_struct);
    end

    // Scoreboard: accept one mul/div from IDLE, count down MULDIV_LAT cycles, done flag
    // registered so it is high exactly in the cycle with cnt == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SB_IDLE;
            cnt_q        <= '0;
            pending_rd_q <= '0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                SB_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.if_id_is_muldiv && !stall) begin
                        state_q      <= SB_BUSY;
                        cnt_q        <= CNT_W'(MULDIV_LAT);
                        pending_rd_q <= bus.if_id_muldiv_rd;
                    end
                end
                default: begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    done_q <= (cnt_q == CNT_W'(2));
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= SB_IDLE;
                        pending_rd_q <= '0;
                        done_q       <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cycles_q;

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles_q <= '0;
        else if (stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign bus.stall_cycles = stall_cycles_q;
`endif

    assign bus.forward_a     = fwd_a;
    assign bus.forward_b     = fwd_b;
    assign bus.alu_src_a     = src_a;
    assign bus.alu_src_b_reg = src_b;
    assign bus.stall         = stall;
    assign bus.id_ex_flush   = stall;
    assign bus.muldiv_busy   = (state_q == SB_BUSY);
    assign bus.muldiv_done   = done_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: forwarding, load-use, scoreboard, structural stall, async reset.
// Latency: checks sampled 1-3 time units after the rising edge, inputs applied just after the edge.
// Backpressure: the bench plays the pipeline, advancing stage contents by hand around each stall.
module tb_hazard_bypass_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hazard_bypass_unit_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    hazard_bypass_unit #(.DATA_W(32), .REG_ADDR_W(5), .MULDIV_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_id_rs = '0; bus.if_id_rt = '0; bus.if_id_uses_rs = 0; bus.if_id_uses_rt = 0;
        bus.if_id_is_muldiv = 0; bus.if_id_muldiv_rd = '0;
        bus.id_ex_rs = '0; bus.id_ex_rt = '0; bus.id_ex_rd = '0; bus.id_ex_mem_read = 0;
        bus.ex_mem_rd = '0; bus.ex_mem_reg_write = 0; bus.ex_mem_alu_result = '0;
        bus.mem_wb_rd = '0; bus.mem_wb_reg_write = 0; bus.mem_wb_data = '0;
        bus.reg_a_data = 32'hAAAA_AAAA; bus.reg_b_data = 32'hBBBB_BBBB;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_inputs();
        #2;
        // Reset state
        check("rst_stall",  64'(bus.stall),       64'd0);
        check("rst_flush",  64'(bus.id_ex_flush), 64'd0);
        check("rst_busy",   64'(bus.muldiv_busy), 64'd0);
        check("rst_done",   64'(bus.muldiv_done), 64'd0);
        check("rst_fwd_a",  64'(bus.forward_a),   64'd0);
`ifdef HAZ_STALL_CNT_EN
        check("rst_stall_cnt", 64'(bus.stall_cycles), 64'd0);
`endif
        // Forwarding follows inputs during reset; stall held low despite a load-use pattern
        bus.id_ex_rs = 5'd3; bus.ex_mem_rd = 5'd3; bus.ex_mem_reg_write = 1;
        bus.ex_mem_alu_result = 32'h0000_1234;
        bus.id_ex_mem_read = 1; bus.id_ex_rd = 5'd5; bus.if_id_rt = 5'd5; bus.if_id_uses_rt = 1;
        #1;
        check("rst_fwd_follow", 64'(bus.forward_a), 64'd2);
        check("rst_stall_gated", 64'(bus.stall), 64'd0);
        step();
        rst_n = 1'b1;
        clear_inputs();
        #1;

        // EX/MEM forward
        bus.id_ex_rs = 5'd3; bus.ex_mem_rd = 5'd3; bus.ex_mem_reg_write = 1;
        bus.ex_mem_alu_result = 32'h0000_1234;
        #1;
        check("exmem_fwd_a", 64'(bus.forward_a), 64'd2);
        check("exmem_src_a", 64'(bus.alu_src_a), 64'h1234);
        // Same rd in MEM/WB: EX/MEM still wins
        bus.mem_wb_rd = 5'd3; bus.mem_wb_reg_write = 1; bus.mem_wb_data = 32'h0000_BEEF;
        #1;
        check("prio_fwd_a", 64'(bus.forward_a), 64'd2);
        check("prio_src_a", 64'(bus.alu_src_a), 64'h1234);
        // EX/MEM not writing: MEM/WB wins, on both operands
        bus.ex_mem_reg_write = 0; bus.id_ex_rt = 5'd3;
        #1;
        check("memwb_fwd_a", 64'(bus.forward_a), 64'd1);
        check("memwb_src_a", 64'(bus.alu_src_a), 64'hBEEF);
        check("memwb_fwd_b", 64'(bus.forward_b), 64'd1);
        check("memwb_src_b", 64'(bus.alu_src_b_reg), 64'hBEEF);
        // r0 never forwarded
        bus.id_ex_rs = 5'd0; bus.id_ex_rt = 5'd0;
        bus.ex_mem_rd = 5'd0; bus.ex_mem_reg_write = 1; bus.mem_wb_rd = 5'd0;
        #1;
        check("r0_fwd_a", 64'(bus.forward_a), 64'd0);
        check("r0_src_a", 64'(bus.alu_src_a), 64'hAAAA_AAAA);
        check("r0_fwd_b", 64'(bus.forward_b), 64'd0);
        clear_inputs();

        // Load-use: lw r5 in EX, reader of rt=r5 in ID; a mul/div in ID must not be accepted while stalled
        step();
        bus.id_ex_mem_read = 1; bus.id_ex_rd = 5'd5; bus.if_id_rt = 5'd5; bus.if_id_uses_rt = 0;
        #1;
        check("lu_no_use", 64'(bus.stall), 64'd0);
        bus.if_id_uses_rt = 1; bus.if_id_is_muldiv = 1; bus.if_id_muldiv_rd = 5'd6;
        #1;
        check("lu_stall", 64'(bus.stall), 64'd1);
        check("lu_flush", 64'(bus.id_ex_flush), 64'd1);
        step();
        check("lu_no_accept", 64'(bus.muldiv_busy), 64'd0);
        // Bubble now in EX, load in MEM
        bus.if_id_is_muldiv = 0;
        bus.id_ex_mem_read = 0; bus.id_ex_rd = 5'd0; bus.ex_mem_rd = 5'd5; bus.ex_mem_reg_write = 1;
        #1;
        check("lu_one_cycle", 64'(bus.stall), 64'd0);
        step();
        // Reader in EX, load in WB
        bus.id_ex_rt = 5'd5; bus.ex_mem_rd = 5'd0; bus.ex_mem_reg_write = 0;
        bus.mem_wb_rd = 5'd5; bus.mem_wb_reg_write = 1; bus.mem_wb_data = 32'h0000_0055;
        bus.if_id_uses_rt = 0;
        #1;
        check("lu_fwd_b", 64'(bus.forward_b), 64'd1);
        check("lu_src_b", 64'(bus.alu_src_b_reg), 64'h55);
        clear_inputs();

        // Mul/div dependency: accept rd=7, reader of r7 stalls 4 cycles
        step();
        bus.if_id_is_muldiv = 1; bus.if_id_muldiv_rd = 5'd7;
        #1;
        check("md_accept_stall", 64'(bus.stall), 64'd0);
        step();
        bus.if_id_is_muldiv = 0; bus.if_id_rs = 5'd7; bus.if_id_uses_rs = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("md_busy_c%0d", k),  64'(bus.muldiv_busy), 64'd1);
            check($sformatf("md_stall_c%0d", k), 64'(bus.stall), 64'd1);
            check($sformatf("md_done_c%0d", k),  64'(bus.muldiv_done), 64'(k == 4));
            step();
        end
        #1;
        check("md_c5_busy",  64'(bus.muldiv_busy), 64'd0);
        check("md_c5_stall", 64'(bus.stall), 64'd0);
        check("md_c5_done",  64'(bus.muldiv_done), 64'd0);
        clear_inputs();

        // Structural: second mul/div one cycle after the first
        step();
        bus.if_id_is_muldiv = 1; bus.if_id_muldiv_rd = 5'd9;
        step();
        bus.if_id_muldiv_rd = 5'd10;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("st_stall_c%0d", k), 64'(bus.stall), 64'd1);
            check($sformatf("st_done_c%0d", k),  64'(bus.muldiv_done), 64'(k == 4));
            step();
        end
        #1;
        check("st_c5_stall", 64'(bus.stall), 64'd0);
        check("st_c5_busy",  64'(bus.muldiv_busy), 64'd0);
        step();
        bus.if_id_is_muldiv = 0;
        #1;
        check("st_reaccept_busy", 64'(bus.muldiv_busy), 64'd1);
        bus.if_id_rs = 5'd9; bus.if_id_uses_rs = 1;
        #1;
        check("st_old_rd_free", 64'(bus.stall), 64'd0);
        bus.if_id_rs = 5'd10;
        #1;
        check("st_new_rd_stall", 64'(bus.stall), 64'd1);

        // Async reset with cnt=2
        step();
        step();
        check("ar_pre_busy", 64'(bus.muldiv_busy), 64'd1);
        check("ar_pre_stall", 64'(bus.stall), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(bus.muldiv_busy), 64'd0);
        check("ar_stall", 64'(bus.stall), 64'd0);
        check("ar_flush", 64'(bus.id_ex_flush), 64'd0);
`ifdef HAZ_STALL_CNT_EN
        check("ar_stall_cnt", 64'(bus.stall_cycles), 64'd0);
`endif
        #2;
        rst_n = 1'b1;
        step();
        check("ar_after_busy", 64'(bus.muldiv_busy), 64'd0);
        check("ar_after_stall", 64'(bus.stall), 64'd0);
        clear_inputs();

        // pending_rd = 0: unit occupied (structural) but no data stall
        bus.if_id_is_muldiv = 1; bus.if_id_muldiv_rd = 5'd0;
        step();
        bus.if_id_is_muldiv = 0; bus.if_id_rs = 5'd0; bus.if_id_uses_rs = 1;
        #1;
        check("r0md_busy", 64'(bus.muldiv_busy), 64'd1);
        check("r0md_no_data_stall", 64'(bus.stall), 64'd0);
        bus.if_id_is_muldiv = 1;
        #1;
        check("r0md_struct_stall", 64'(bus.stall), 64'd1);
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
